// File: rtl/hazard_control.sv
// -----------------------------------------------------------------------------
// hazard_control
//
// Pipeline hazard controller sitting beside the decode stage. It tracks the
// destination registers of the instructions in flight (EX, MEM, WB) in a small
// shift-register scoreboard. It compares the decoding instruction's source
// registers against that scoreboard to detect read-after-write hazards, and it
// drives the pipeline stall / squash controls:
//   - RAW hazard     : hold fetch/decode and inject a bubble until the producer
//                      has retired from the scoreboard.
//   - taken jump     : squash the wrong-path instruction(s) for SQUASH_CYCLES.
//   - memory busy    : freeze the whole pipeline, including this block.
//
// Ports
//   clk            in   1      clock, rising edge
//   rst            in   1      asynchronous reset, active low
//   a0             in   5      source register 1 of the decoding instruction
//   a1             in   5      source register 2 of the decoding instruction
//   a2_hazard      in   5      destination register of the decoding instruction
//                              (0 = no register write)
//   jmp_taken      in   1      execute stage resolved a taken jump this cycle
//   mem_busy       in   1      memory not ready, whole pipeline freezes
//   stall          out  1      stall input of every pipeline latch
//   stall_fetch    out  1      hold PC and the fetch/decode instruction register
//   squash         out  1      bubble into the decode output latches
//   hazard_stalls  out  CNT_W  saturating count of RAW-stall cycles
// -----------------------------------------------------------------------------
module hazard_control #(
    parameter int DEPTH         = 3,
    parameter int SQUASH_CYCLES = 2,
    parameter int CNT_W         = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       a0,
    input  logic [4:0]       a1,
    input  logic [4:0]       a2_hazard,
    input  logic             jmp_taken,
    input  logic             mem_busy,
    output logic             stall,
    output logic             stall_fetch,
    output logic             squash,
    output logic [CNT_W-1:0] hazard_stalls
);

    // Wide enough to hold SQUASH_CYCLES-1 for any SQUASH_CYCLES >= 1.
    localparam int SQ_W = $clog2(SQUASH_CYCLES) + 1;

    logic [4:0]      sb [DEPTH];   // sb[0] = EX, sb[DEPTH-1] = oldest (WB)
    logic [SQ_W-1:0] sq_cnt;       // remaining extra squash cycles after a jump
    logic            hazard;
    logic            flushing;

    // -------------------------------------------------------------------------
    // Same-cycle hazard detection and control outputs.
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path
        // leaves it unassigned and no latch is inferred.
        hazard = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            // Register x0 is hard-wired zero; reading it never depends on
            // an in-flight write.
            if ((a0 != 5'd0 && a0 == sb[i]) || (a1 != 5'd0 && a1 == sb[i]))
                hazard = 1'b1;
        end
    end

    assign flushing    = jmp_taken | (sq_cnt != '0);
    assign stall       = mem_busy;
    assign squash      = flushing | hazard;
    // A flush redirects the PC anyway, so the hazard's fetch hold is dropped.
    assign stall_fetch = mem_busy | (hazard & ~flushing);

    // -------------------------------------------------------------------------
    // Scoreboard shift, squash timer and stall counter. Everything holds while
    // memory is busy; a jump seen during that time is not acted on.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            // NOTE: the scoreboard is a handful of flops, not a RAM, and a
            // stale entry after reset would raise a false hazard, so every
            // entry is cleared.
            for (int i = 0; i < DEPTH; i++)
                sb[i] <= 5'd0;
            sq_cnt        <= '0;
            hazard_stalls <= '0;
        end else if (!mem_busy) begin
            // NOTE: non-blocking assignments let sb[i] take the old sb[i-1]
            // regardless of the order the loop writes them.
            sb[0] <= squash ? 5'd0 : a2_hazard;
            for (int i = 1; i < DEPTH; i++)
                sb[i] <= sb[i-1];

            if (jmp_taken)
                sq_cnt <= SQ_W'(SQUASH_CYCLES - 1);
            else if (sq_cnt != '0)
                sq_cnt <= sq_cnt - SQ_W'(1);

            if (hazard && !flushing && hazard_stalls != '1)
                hazard_stalls <= hazard_stalls + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_hazard_control.sv
// -----------------------------------------------------------------------------
// tb_hazard_control
//
// Drives two hazard_control instances (16-bit and 4-bit stall counters) with
// identical stimulus: directed scenarios followed by random traffic. Expected
// outputs come from a reference model that keeps the in-flight destination
// registers as a plain list and the pending squash length as an integer.
// Inputs change on the falling edge; outputs are sampled 1 ns later.
// -----------------------------------------------------------------------------
module tb_hazard_control;

    localparam int DEPTH         = 3;
    localparam int SQUASH_CYCLES = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  a0, a1, a2_hazard;
    logic        jmp_taken, mem_busy;

    logic        stall, stall_fetch, squash;
    logic [15:0] hazard_stalls;
    logic        stall_s, stall_fetch_s, squash_s;
    logic [3:0]  hazard_stalls_s;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state.
    int m_inflight[$];   // dest regs of in-flight instructions, newest first
    int m_sq_left;       // further cycles of squash still owed to a jump
    int m_cnt16;
    int m_cnt4;

    always #5 clk = ~clk;

    hazard_control #(.DEPTH(DEPTH), .SQUASH_CYCLES(SQUASH_CYCLES), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .a0(a0), .a1(a1), .a2_hazard(a2_hazard),
        .jmp_taken(jmp_taken), .mem_busy(mem_busy),
        .stall(stall), .stall_fetch(stall_fetch), .squash(squash),
        .hazard_stalls(hazard_stalls)
    );

    hazard_control #(.DEPTH(DEPTH), .SQUASH_CYCLES(SQUASH_CYCLES), .CNT_W(4)) dut_sat (
        .clk(clk), .rst(rst), .a0(a0), .a1(a1), .a2_hazard(a2_hazard),
        .jmp_taken(jmp_taken), .mem_busy(mem_busy),
        .stall(stall_s), .stall_fetch(stall_fetch_s), .squash(squash_s),
        .hazard_stalls(hazard_stalls_s)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic bit m_in_flight(input int r);
        if (r == 0) return 1'b0;
        foreach (m_inflight[i])
            if (m_inflight[i] == r) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_reset();
        m_inflight.delete();
        for (int i = 0; i < DEPTH; i++) m_inflight.push_back(0);
        m_sq_left = 0;
        m_cnt16   = 0;
        m_cnt4    = 0;
    endtask

    // Compare every output against the model for the current inputs.
    task automatic check_outputs(input string tag);
        bit hz, fl;
        hz = m_in_flight(int'(a0)) || m_in_flight(int'(a1));
        fl = jmp_taken || (m_sq_left > 0);
        check({tag, ".stall"},       32'(stall),          32'(mem_busy));
        check({tag, ".squash"},      32'(squash),         32'(fl || hz));
        check({tag, ".stall_fetch"}, 32'(stall_fetch),    32'(mem_busy || (hz && !fl)));
        check({tag, ".cnt16"},       32'(hazard_stalls),  32'(m_cnt16));
        check({tag, ".cnt4"},        32'(hazard_stalls_s), 32'(m_cnt4));
    endtask

    // Advance the model across the coming rising edge.
    task automatic model_clock();
        bit hz, fl;
        if (mem_busy) return;
        hz = m_in_flight(int'(a0)) || m_in_flight(int'(a1));
        fl = jmp_taken || (m_sq_left > 0);
        m_inflight.push_front((fl || hz) ? 0 : int'(a2_hazard));
        void'(m_inflight.pop_back());
        if (jmp_taken)          m_sq_left = SQUASH_CYCLES - 1;
        else if (m_sq_left > 0) m_sq_left--;
        if (hz && !fl) begin
            if (m_cnt16 < 65535) m_cnt16++;
            if (m_cnt4  < 15)    m_cnt4++;
        end
    endtask

    // One pipeline cycle: called at a falling edge, returns at the next one.
    task automatic step(input string tag, input logic [4:0] s0, input logic [4:0] s1,
                        input logic [4:0] d, input logic j, input logic mb);
        a0 = s0; a1 = s1; a2_hazard = d; jmp_taken = j; mem_busy = mb;
        #1;
        check_outputs(tag);
        model_clock();
        @(negedge clk);
    endtask

    // Asynchronous reset asserted mid-cycle; inputs left as they are.
    task automatic pulse_reset(input string tag);
        #2 rst = 1'b0;
        model_reset();
        #1;
        check_outputs(tag);
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        rst = 1'b0;
        a0 = 5'd0; a1 = 5'd0; a2_hazard = 5'd0; jmp_taken = 1'b0; mem_busy = 1'b0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;

        // Reset state.
        step("reset_state", 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);

        // Reset clears a filled scoreboard; a0=5 must not hazard afterwards.
        step("fill0", 5'd0, 5'd0, 5'd5, 1'b0, 1'b0);
        step("fill1", 5'd0, 5'd0, 5'd6, 1'b0, 1'b0);
        step("fill2", 5'd0, 5'd0, 5'd7, 1'b0, 1'b0);
        a0 = 5'd5; a2_hazard = 5'd0;
        pulse_reset("async_reset");
        step("post_reset", 5'd5, 5'd0, 5'd0, 1'b0, 1'b0);
        check("post_reset.no_stall_fetch", 32'(stall_fetch), 32'd0);

        // RAW on the immediately preceding producer: DEPTH stall cycles.
        pulse_reset("rst_before_raw");
        step("raw.prod", 5'd0, 5'd0, 5'd5, 1'b0, 1'b0);
        for (int c = 1; c <= 4; c++) begin
            a0 = 5'd5; a1 = 5'd0; a2_hazard = 5'd0; jmp_taken = 1'b0; mem_busy = 1'b0;
            #1;
            check($sformatf("raw.cyc%0d.stall_fetch", c), 32'(stall_fetch), 32'(c <= 3));
            check_outputs($sformatf("raw.cyc%0d", c));
            model_clock();
            @(negedge clk);
        end
        check("raw.count", 32'(hazard_stalls), 32'd3);

        // x0 and unrelated registers never stall.
        step("x0.prod",   5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        step("x0.use",    5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        step("nodep.prod", 5'd0, 5'd0, 5'd9, 1'b0, 1'b0);
        step("nodep.use", 5'd0, 5'd8, 5'd0, 1'b0, 1'b0);
        check("nodep.squash", 32'(squash), 32'd0);

        // Jump colliding with a hazard: flush wins, no stall count.
        pulse_reset("rst_before_jmp");
        step("jmp.prod", 5'd0, 5'd0, 5'd5, 1'b0, 1'b0);
        step("jmp.cyc1", 5'd5, 5'd0, 5'd3, 1'b1, 1'b0);
        step("jmp.cyc2", 5'd0, 5'd0, 5'd4, 1'b0, 1'b0);
        step("jmp.cyc3", 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        check("jmp.count", 32'(hazard_stalls), 32'd0);
        check("jmp.squash_over", 32'(squash), 32'd0);

        // Freeze in the middle of a RAW stall.
        pulse_reset("rst_before_freeze");
        step("frz.prod", 5'd0, 5'd0, 5'd5, 1'b0, 1'b0);
        step("frz.cyc1", 5'd5, 5'd0, 5'd0, 1'b0, 1'b0);
        for (int c = 2; c <= 5; c++)
            step($sformatf("frz.cyc%0d", c), 5'd5, 5'd0, 5'd0, 1'b1, 1'b1);
        step("frz.cyc6", 5'd5, 5'd0, 5'd0, 1'b0, 1'b0);
        step("frz.cyc7", 5'd5, 5'd0, 5'd0, 1'b0, 1'b0);
        step("frz.cyc8", 5'd5, 5'd0, 5'd0, 1'b0, 1'b0);
        check("frz.count", 32'(hazard_stalls), 32'd3);

        // Saturation: 18 RAW stall cycles, the 4-bit counter stops at 15.
        pulse_reset("rst_before_sat");
        for (int r = 0; r < 6; r++) begin
            step("sat.prod", 5'd0, 5'd0, 5'd5, 1'b0, 1'b0);
            for (int c = 0; c < 3; c++)
                step("sat.use", 5'd0, 5'd5, 5'd5, 1'b0, 1'b0);
        end
        check("sat.cnt4", 32'(hazard_stalls_s), 32'd15);
        check("sat.cnt16", 32'(hazard_stalls), 32'd18);

        // Random traffic over a small register set to make collisions common.
        for (int n = 0; n < 400; n++) begin
            step("rand",
                 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                 5'($urandom_range(0, 3)),
                 1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 5) == 0));
            if (n == 200) pulse_reset("rand.reset");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
